// File: rtl/ptw_walker_pkg.sv
// rtl/ptw_walker_pkg.sv - Sv39 walker types, widths and PTE address helper
package ptw_walker_pkg;

  localparam int VPN_W         = 27;
  localparam int PPN_W         = 20;
  localparam int PADDR_W       = 32;
  localparam int LEVELS        = 3;
  localparam int PTE_SIZE_LOG2 = 3;
  localparam int VPN_SLICE_W   = 9;
  localparam int PTE_PPN_W     = 44;

  typedef enum logic [1:0] {
    PTW_IDLE,
    PTW_MEM_REQ,
    PTW_MEM_WAIT,
    PTW_RESP
  } ptw_state_t;

  typedef struct packed {
    logic [9:0]           reserved;
    logic [PTE_PPN_W-1:0] ppn;
    logic [1:0]           rfs;
    logic                 d;
    logic                 a;
    logic                 g;
    logic                 u;
    logic                 x;
    logic                 w;
    logic                 r;
    logic                 v;
  } pte_t;

  typedef struct packed {
    logic               valid;
    logic [PADDR_W-1:0] addr;
  } ptw_mem_req_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } ptw_mem_resp_t;

  // PTE address for one level: table base, the VPN slice of that level, 8-byte entries
  function automatic logic [PADDR_W-1:0] pte_addr(input logic [PPN_W-1:0] base,
                                                  input logic [VPN_W-1:0] vpn,
                                                  input logic [1:0]       lvl);
    logic [VPN_SLICE_W-1:0] idx;
    case (lvl)
      2'd2:    idx = vpn[26:18];
      2'd1:    idx = vpn[17:9];
      default: idx = vpn[8:0];
    endcase
    return {base, idx, {PTE_SIZE_LOG2{1'b0}}};
  endfunction

endpackage

// File: rtl/ptw_walker_pte_check.sv
// rtl/ptw_walker_pte_check.sv - classifies a fetched Sv39 PTE as invalid, leaf or pointer
module ptw_pte_check
  import ptw_walker_pkg::*;
(
  input  logic [63:0] pte,
  input  logic [1:0]  lvl,
  output logic        is_leaf,
  output logic        is_invalid,
  output logic        misaligned
);

  pte_t p;
  assign p = pte_t'(pte);

  // superpage leaves must have the PPN bits covered by the page offset cleared
  always_comb begin
    is_invalid = !p.v || (p.w && !p.r);
    is_leaf    = p.r || p.x;
    case (lvl)
      2'd2:    misaligned = |p.ppn[17:0];
      2'd1:    misaligned = |p.ppn[8:0];
      default: misaligned = 1'b0;
    endcase
  end

  logic unused_pte_bits;
  assign unused_pte_bits = ^{p.reserved, p.ppn[PTE_PPN_W-1:18], p.rfs, p.d, p.a, p.g, p.u};

endmodule

// File: rtl/ptw_walker.sv
// rtl/ptw_walker.sv - Sv39 page-table walker on the TLB miss path, single outstanding PTE read
module ptw_walker
  import ptw_walker_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ptw_req_i_valid,
  input  logic [VPN_W-1:0]   ptw_req_i_addr,
  input  logic [1:0]         ptw_req_i_prv,
  input  logic               ptw_req_i_store,
  input  logic               ptw_req_i_fetch,
  output logic               ptw_req_ready_o,
  output logic               ptw_resp_o_valid,
  output logic               ptw_resp_o_error,
  output logic [63:0]        ptw_resp_o_pte,
  output logic [1:0]         ptw_resp_o_level,
  output logic               ptw_invalidate_o,
  input  logic [PPN_W-1:0]   csr_satp_ppn_i,
  input  logic               csr_flush_i,
  output logic               mem_req_o_valid,
  output logic [PADDR_W-1:0] mem_req_o_addr,
  input  logic               mem_req_i_ready,
  input  logic               mem_resp_i_valid,
  input  logic [63:0]        mem_resp_i_data
);

  ptw_state_t         state_q, state_d;
  logic [VPN_W-1:0]   vpn_q;
  logic [1:0]         prv_q;
  logic               store_q, fetch_q;
  logic [1:0]         lvl_q;
  logic [PPN_W-1:0]   base_q;
  pte_t               pte_q;
  logic               err_q, kill_q, inval_q;
  ptw_mem_req_t       mem_req;

  pte_t pte_in;
  logic is_leaf, is_invalid, misaligned;
  logic fault, descend, walk_killed, accept;

  assign pte_in = pte_t'(mem_resp_i_data);

  ptw_pte_check u_pte_check (
    .pte        (mem_resp_i_data),
    .lvl        (lvl_q),
    .is_leaf    (is_leaf),
    .is_invalid (is_invalid),
    .misaligned (misaligned)
  );

  assign accept      = (state_q == PTW_IDLE) && ptw_req_i_valid;
  assign fault       = is_invalid || (is_leaf && misaligned) || (!is_leaf && lvl_q == 2'd0);
  assign descend     = !is_invalid && !is_leaf && (lvl_q != 2'd0);
  assign walk_killed = kill_q || csr_flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= PTW_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PTW_IDLE:     if (ptw_req_i_valid) state_d = PTW_MEM_REQ;
      // a flush that lands on the handshake still has a read in flight, so wait it out
      PTW_MEM_REQ:  if (mem_req_i_ready) state_d = PTW_MEM_WAIT;
                    else if (csr_flush_i) state_d = PTW_IDLE;
      PTW_MEM_WAIT: if (mem_resp_i_valid) begin
                      if (walk_killed)  state_d = PTW_IDLE;
                      else if (descend) state_d = PTW_MEM_REQ;
                      else              state_d = PTW_RESP;
                    end
      PTW_RESP:     state_d = PTW_IDLE;
      default:      state_d = PTW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vpn_q   <= '0;
      prv_q   <= '0;
      store_q <= 1'b0;
      fetch_q <= 1'b0;
      lvl_q   <= '0;
      base_q  <= '0;
      pte_q   <= '0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
      inval_q <= 1'b0;
    end else begin
      inval_q <= csr_flush_i;
      if (accept) begin
        vpn_q   <= ptw_req_i_addr;
        prv_q   <= ptw_req_i_prv;
        store_q <= ptw_req_i_store;
        fetch_q <= ptw_req_i_fetch;
        lvl_q   <= 2'(LEVELS - 1);
        base_q  <= csr_satp_ppn_i;
        pte_q   <= '0;
        err_q   <= 1'b0;
        kill_q  <= 1'b0;
      end
      if (state_q == PTW_MEM_REQ && mem_req_i_ready && csr_flush_i) kill_q <= 1'b1;
      if (state_q == PTW_MEM_WAIT) begin
        if (csr_flush_i) kill_q <= 1'b1;
        if (mem_resp_i_valid) begin
          kill_q <= 1'b0;
          if (!walk_killed) begin
            pte_q <= pte_in;
            err_q <= fault;
            if (descend) begin
              base_q <= pte_in.ppn[PPN_W-1:0];
              lvl_q  <= lvl_q - 2'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    mem_req.valid    = (state_q == PTW_MEM_REQ);
    mem_req.addr     = '0;
    ptw_req_ready_o  = (state_q == PTW_IDLE);
    ptw_resp_o_valid = 1'b0;
    ptw_resp_o_error = 1'b0;
    ptw_resp_o_pte   = '0;
    ptw_resp_o_level = '0;
    if (state_q == PTW_MEM_REQ) mem_req.addr = pte_addr(base_q, vpn_q, lvl_q);
    if (state_q == PTW_RESP) begin
      ptw_resp_o_valid = 1'b1;
      ptw_resp_o_error = err_q;
      ptw_resp_o_pte   = err_q ? 64'h0 : 64'(pte_q);
      ptw_resp_o_level = lvl_q;
    end
  end

  assign mem_req_o_valid  = mem_req.valid;
  assign mem_req_o_addr   = mem_req.addr;
  assign ptw_invalidate_o = inval_q;

  // requester attributes are held for debug visibility only
  logic unused_req_attr;
  assign unused_req_attr = ^{prv_q, store_q, fetch_q};

endmodule
